// File: rtl/rca_word_sequencer.sv
// Byte-serial add/subtract sequencer driving one shared external 8-bit ripple-carry adder.
// Operands are processed LSB byte first; the carry chains between bytes in a register.
module rca_word_sequencer #(
   parameter int unsigned BYTES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic [8*BYTES-1:0]   a,
   input  logic [8*BYTES-1:0]   b,
   input  logic                 cin,
   input  logic                 sub,
   output logic [7:0]           add_a,
   output logic [7:0]           add_b,
   output logic                 add_cin,
   input  logic [7:0]           add_sum,
   input  logic                 add_carry,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [8*BYTES-1:0]   sum,
   output logic                 cout,
   output logic                 ovf
);

   localparam int unsigned W    = 8 * BYTES;
   localparam int unsigned IW   = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int unsigned LAST = BYTES - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_idx;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [7:0]      r_add_a;
   logic [7:0]      r_add_b;
   logic            r_add_cin;
   logic [W-1:0]    r_sum;
   logic            r_cout;
   logic            r_ovf;
   logic            r_res_valid;
   logic            r_start_ready;

   logic [W-1:0]    w_b_eff;
   logic            w_cin_eff;
   logic            w_last;
   logic            w_ovf;

   assign w_b_eff   = sub ? ~b : b;
   assign w_cin_eff = sub | cin;
   assign w_last    = (r_idx == IW'(LAST));
   // On the last byte the adder inputs hold the operand MSB bytes, so signed overflow is visible here.
   assign w_ovf     = (r_add_a[7] == r_add_b[7]) && (add_sum[7] != r_add_a[7]);

   // r_a/r_b hold the not-yet-issued bytes, shifted down one byte per RUN cycle.
   // r_add_cin doubles as the inter-byte carry register while in RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_idx         <= '0;
         r_a           <= '0;
         r_b           <= '0;
         r_add_a       <= '0;
         r_add_b       <= '0;
         r_add_cin     <= 1'b0;
         r_sum         <= '0;
         r_cout        <= 1'b0;
         r_ovf         <= 1'b0;
         r_res_valid   <= 1'b0;
         r_start_ready <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_valid) begin
                  r_a           <= a >> 8;
                  r_b           <= w_b_eff >> 8;
                  r_add_a       <= a[7:0];
                  r_add_b       <= w_b_eff[7:0];
                  r_add_cin     <= w_cin_eff;
                  r_idx         <= '0;
                  r_start_ready <= 1'b0;
                  r_state       <= S_RUN;
               end
            end
            S_RUN: begin
               r_sum[{r_idx, 3'b000} +: 8] <= add_sum;
               if (w_last) begin
                  r_add_a     <= '0;
                  r_add_b     <= '0;
                  r_add_cin   <= 1'b0;
                  r_cout      <= add_carry;
                  r_ovf       <= w_ovf;
                  r_res_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_idx     <= r_idx + IW'(1);
                  r_add_a   <= r_a[7:0];
                  r_add_b   <= r_b[7:0];
                  r_add_cin <= add_carry;
                  r_a       <= r_a >> 8;
                  r_b       <= r_b >> 8;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  r_res_valid   <= 1'b0;
                  r_start_ready <= 1'b1;
                  r_state       <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign start_ready = r_start_ready;
   assign add_a       = r_add_a;
   assign add_b       = r_add_b;
   assign add_cin     = r_add_cin;
   assign res_valid   = r_res_valid;
   assign sum         = r_sum;
   assign cout        = r_cout;
   assign ovf         = r_ovf;

endmodule

// File: doc/rca_word_sequencer.md
Name: rca_word_sequencer

Overview:
Sequences one shared combinational 8-bit ripple-carry adder (RCA_8bit) to add or subtract multi-byte operands, one byte per clock, LSB first. The carry is chained between bytes in a register. Operands enter through a valid/ready request port, and results leave through a valid/ready result port. The block sits between a requester (e.g. an ALU front end) and the single RCA_8bit instance, which it drives through dedicated adder ports.

Parameters:
BYTES, 4, operand width in bytes (legal range 1 to 16); the operand width W = 8*BYTES.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
start_valid  in  1  request valid
start_ready  out  1  block can accept a request
a  in  W  operand A, sampled only on acceptance
b  in  W  operand B, sampled only on acceptance
cin  in  1  carry-in for add mode, sampled on acceptance
sub  in  1  0 = a+b+cin; 1 = a-b (cin ignored), sampled on acceptance
add_a  out  8  adder operand A byte
add_b  out  8  adder operand B byte (already inverted in sub mode)
add_cin  out  1  adder carry-in
add_sum  in  8  adder sum, combinational from add_a/add_b/add_cin
add_carry  in  1  adder carry-out
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
sum  out  W  result
cout  out  1  final carry-out; in sub mode 1 = no borrow
ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset: on rst high at a clock edge, state = IDLE, byte index = 0, carry reg = 0. The following outputs are 0: sum, cout, ovf, res_valid, add_a, add_b, add_cin. start_ready = 1 after reset.
- rst has priority over every other event. Reset during RUN or DONE aborts the operation, the result is discarded, and res_valid is never asserted for that operation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - When start_valid is high, the block latches a, b and sub.
  - It sets the effective B to ~b if sub = 1, otherwise b.
  - It sets carry reg to 1 if sub = 1, otherwise cin.
  - It sets idx = 0 and moves to RUN.
- RUN:
  - start_ready = 0.
  - add_a = A byte[idx], add_b = effective B byte[idx], add_cin = carry reg.
  - On each edge: sum byte[idx] <= add_sum, carry reg <= add_carry.
  - If idx = BYTES-1, go to DONE; otherwise idx increments.
- DONE:
  - res_valid = 1; sum, cout (= carry reg) and ovf are held stable.
  - ovf = (A[W-1] == effB[W-1]) && (sum[W-1] != A[W-1]).
  - On res_ready high, go to IDLE with res_valid = 0 on the next cycle.
- Outside RUN, add_a, add_b and add_cin are driven 0.
- Latency: res_valid rises exactly BYTES cycles after the accepting edge. With BYTES=1, DONE follows after one RUN cycle.
- Throughput: one operation per BYTES+2 cycles minimum. There is no back-to-back acceptance: start_ready is low in RUN and DONE, and start_valid is ignored there. The next request is accepted in IDLE, one cycle after the result handshake.
- Wrap-around: the result is modulo 2^W, and the carry beyond the MSB appears only on cout.
- Input changes on a, b, cin or sub after acceptance have no effect on the operation in flight.
- sum retains the last result after the return to IDLE; only a new operation overwrites it.

Test Plan:
1. BYTES=4, a=0x0000000F, b=0x00000005, cin=0, sub=0 -> res_valid exactly 4 cycles after acceptance; sum=0x00000014, cout=0, ovf=0. add_a sequence is 0x0F,0x00,0x00,0x00.
2. a=0xFFFFFFFF, b=0xFFFFFFFF, cin=0 -> sum=0xFFFFFFFE, cout=1, ovf=0. Then a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1.
3. Inter-byte carry: a=0x00FFFFFF, b=0x00000000, cin=1 -> sum=0x01000000, cout=0. Check that add_cin=1 in every RUN cycle.
4. Subtract: a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
5. Backpressure: hold res_ready=0 for 6 cycles with start_valid=1 and new operands -> res_valid, sum, cout and ovf are stable; start_ready=0; no new acceptance. After res_ready pulses high, the new request is accepted in IDLE on the following cycle.
6. Reset mid-RUN (rst high while idx=2) -> next cycle state IDLE, start_ready=1, and res_valid, add_* and sum are 0. A following op 0x12345678+0x11111111 gives 0x23456789, cout=0.
